// File: rtl/dense_pkg.sv
// dense_pkg: shared encodings, Q4.12 constants and FSM state type for the dense layers.
package dense_pkg;
    localparam int ACT_TANH = 0;
    localparam int ACT_SIGM = 1;
    localparam int ACT_RELU = 2;
    localparam int Q_ONE = 4096;
    localparam int Q_HALF = 2048;
    localparam int BIAS_SHL = 12;
    localparam int ACC_SHR = 8;
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_ACT, S_DONE} state_t;

    function automatic logic signed [31:0] clamp(input logic signed [31:0] v,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
        return v < lo ? lo : (v > hi ? hi : v);
    endfunction
endpackage

// File: rtl/input_dense_if.sv
// input_dense_if: frame request, weight/bias ROM fetch and result bus of input_dense.
interface input_dense_if #(
    parameter int M = 42,
    parameter int N = 24,
    parameter int IN_W = 16,
    parameter int W_W = 8,
    parameter int OUT_W = 16
);
    localparam int AW = M * N > 1 ? $clog2(M * N) : 1;
    localparam int BW = N > 1 ? $clog2(N) : 1;

    logic                 start;
    logic [M*IN_W-1:0]    feat_in;
    logic [AW-1:0]        w_addr;
    logic [W_W-1:0]       w_data;
    logic [BW-1:0]        b_addr;
    logic [W_W-1:0]       b_data;
    logic                 busy;
    logic                 done;
    logic [N*OUT_W-1:0]   dense_out;

    modport master (
        output start, feat_in, w_data, b_data,
        input  w_addr, b_addr, busy, done, dense_out
    );

    modport slave (
        input  start, feat_in, w_data, b_data,
        output w_addr, b_addr, busy, done, dense_out
    );
endinterface

// File: rtl/dense_act.sv
// dense_act: saturates a scale-2^-20 accumulator to Q4.12 and applies the selected activation.
module dense_act
    import dense_pkg::*;
#(
    parameter int ACT = ACT_TANH,
    parameter int OUT_W = 16
) (
    input  logic signed [31:0] acc,
    output logic [OUT_W-1:0]   y
);
    logic signed [31:0] pre, act_v;

    always_comb begin
        pre = clamp(acc >>> ACC_SHR, SAT_MIN, SAT_MAX);
        act_v = ACT == ACT_SIGM ? clamp((pre >>> 2) + Q_HALF, 0, Q_ONE)
              : ACT == ACT_RELU ? (pre < 0 ? 0 : pre)
              : clamp(pre, -Q_ONE, Q_ONE);
        y = OUT_W'(act_v);
    end
endmodule

// File: rtl/input_dense.sv
// input_dense: fully-connected layer computing N neurons over M features with one
// time-multiplexed MAC; results land in a shadow and are published all at once.
module input_dense
    import dense_pkg::*;
#(
    parameter int M = 42,
    parameter int N = 24,
    parameter int IN_W = 16,
    parameter int W_W = 8,
    parameter int OUT_W = 16,
    parameter int ACT = ACT_TANH
) (
    input logic clk,
    input logic rst,
    input_dense_if.slave io
);
    localparam int AW = M * N > 1 ? $clog2(M * N) : 1;
    localparam int BW = N > 1 ? $clog2(N) : 1;
    localparam int KW = $clog2(M + 2);
    localparam int FW = M * IN_W;

    state_t state, nxt;
    logic [KW-1:0]         k;
    logic [FW-1:0]         feat;
    logic signed [31:0]    acc;
    logic [N*OUT_W-1:0]    shadow, shadow_nxt;
    logic [OUT_W-1:0]      act_y;
    logic signed [W_W-1:0] wv, bv;
    logic signed [IN_W-1:0] xv;
    logic                  last_j;

    dense_act #(.ACT(ACT), .OUT_W(OUT_W)) u_act (.acc(acc), .y(act_y));

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        last_j = io.b_addr == BW'(N - 1);
        case (state)
            S_IDLE: if (io.start) nxt = S_BIAS;
            S_BIAS: nxt = S_MAC;
            S_MAC:  if (k == KW'(M)) nxt = S_ACT;
            S_ACT:  if (last_j) nxt = S_DONE; else nxt = S_BIAS;
            default: nxt = S_IDLE;
        endcase
        io.busy = state inside {S_BIAS, S_MAC, S_ACT};
        io.done = state == S_DONE;
        wv = io.w_data;
        bv = io.b_data;
        xv = feat[IN_W-1:0];
        shadow_nxt = shadow;
        shadow_nxt[io.b_addr * OUT_W +: OUT_W] = act_y;
    end

    // b_addr doubles as the neuron index j; feat rotates so x[k-1] is always the low element.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            k <= '0;
            feat <= '0;
            acc <= '0;
            shadow <= '0;
            io.dense_out <= '0;
            io.w_addr <= '0;
            io.b_addr <= '0;
        end else begin
            if (state == S_IDLE && io.start) begin
                feat <= io.feat_in;
                io.w_addr <= '0;
                io.b_addr <= '0;
            end
            if (state == S_BIAS) k <= '0;
            if (state == S_MAC) begin
                k <= k + KW'(1);
                acc <= k == '0 ? 32'(bv) <<< BIAS_SHL : acc + 32'(wv) * 32'(xv);
                if (k != '0) feat <= FW'({feat, feat} >> IN_W);
                if (32'(k) + 1 < M) io.w_addr <= io.w_addr + AW'(N);
            end
            // The last neuron publishes the whole vector directly so done and dense_out coincide.
            if (state == S_ACT) begin
                shadow <= shadow_nxt;
                if (last_j) io.dense_out <= shadow_nxt;
                else begin
                    io.b_addr <= io.b_addr + BW'(1);
                    io.w_addr <= AW'(io.b_addr) + AW'(1);
                end
            end
        end
endmodule

// File: tb/tb_input_dense.sv
// tb_input_dense: directed checks of input_dense with all three activations side by side.
module tb_input_dense;
    localparam int M = 42, N = 24, IN_W = 16, W_W = 8, OUT_W = 16;
    localparam int LAT = N * (M + 3) + 1;

    logic clk = 0, rst = 1, start = 0;
    logic [M*IN_W-1:0] feat = '0;
    logic [W_W-1:0] wrom [M*N];
    logic [W_W-1:0] brom [N];
    logic [N*OUT_W-1:0] dout [3];
    logic [N*OUT_W-1:0] exp_v [3];
    logic done_v [3];
    logic busy_v [3];
    logic [9:0] waddr;
    logic [4:0] baddr;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        input_dense_if #(.M(M), .N(N), .IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W)) bus ();
        input_dense #(.M(M), .N(N), .IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W), .ACT(g)) dut (
            .clk(clk), .rst(rst), .io(bus)
        );
        assign bus.start = start;
        assign bus.feat_in = feat;
        always @(posedge clk) begin
            bus.w_data <= wrom[bus.w_addr];
            bus.b_data <= brom[bus.b_addr];
        end
        assign dout[g] = bus.dense_out;
        assign done_v[g] = bus.done;
        assign busy_v[g] = bus.busy;
    end
    assign waddr = g_dut[0].bus.w_addr;
    assign baddr = g_dut[0].bus.b_addr;

    task automatic fill(input logic [7:0] w, input logic [7:0] b);
        for (int i = 0; i < M * N; i++) wrom[i] = w;
        for (int j = 0; j < N; j++) brom[j] = b;
    endtask

    task automatic set_x(input int i, input logic [15:0] v);
        feat[i*IN_W +: IN_W] = v;
    endtask

    task automatic set_exp(input logic [15:0] t, input logic [15:0] s, input logic [15:0] r);
        exp_v[0] = {N{t}};
        exp_v[1] = {N{s}};
        exp_v[2] = {N{r}};
    endtask

    // Leaves the bench #1 after the accepting edge, i.e. in cycle 1.
    task automatic kick();
        @(posedge clk);
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done_v[0] !== 1'b1 && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if ({done_v[a], busy_v[a]} !== 2'b00 || dout[a] !== '0) begin
                n_fail++;
                $display("FAIL reset act%0d: done/busy %b%b out %h, expected 00 and zero", a, done_v[a], busy_v[a], dout[a]);
            end
        end
        n_chk++;
        if (waddr !== 10'd0 || baddr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_addr: w_addr %0d b_addr %0d, expected 0 0", waddr, baddr);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_bias();
        int lat;
        fill(8'd0, 8'd1);
        feat = '0;
        kick();
        n_chk++;
        if (busy_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise: busy %b, expected 1", busy_v[0]);
        end
        wait_done(lat);
        n_chk++;
        if (lat != LAT || busy_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bias_latency: done at %0d busy %b, expected %0d busy 0", lat, busy_v[0], LAT);
        end
        set_exp(16'd16, 16'd2052, 16'd16);
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a]) begin
                n_fail++;
                $display("FAIL bias act%0d: got %h expected %h", a, dout[a], exp_v[a]);
            end
        end
    endtask

    task automatic test_weight();
        int lat;
        fill(8'd0, 8'd0);
        for (int j = 0; j < N; j++) wrom[j] = 8'd64;
        feat = '0;
        set_x(0, 16'd4096);
        kick();
        wait_done(lat);
        n_chk++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL weight_latency: done at %0d, expected %0d", lat, LAT);
        end
        set_exp(16'd1024, 16'd2304, 16'd1024);
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a]) begin
                n_fail++;
                $display("FAIL weight act%0d: got %h expected %h", a, dout[a], exp_v[a]);
            end
        end
    endtask

    task automatic test_pairing();
        int lat;
        fill(8'd0, 8'd0);
        for (int j = 0; j < N; j++) begin
            wrom[j] = 8'd64;
            wrom[N + j] = 8'hE0;
            wrom[(M - 1) * N + j] = 8'd16;
        end
        feat = '0;
        set_x(1, 16'd4096);
        set_x(M - 1, 16'd4096);
        kick();
        wait_done(lat);
        set_exp(16'hFF00, 16'd1984, 16'd0);
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a]) begin
                n_fail++;
                $display("FAIL pairing act%0d: got %h expected %h", a, dout[a], exp_v[a]);
            end
        end
    endtask

    task automatic test_floor();
        int lat;
        fill(8'd0, 8'd0);
        for (int j = 0; j < N; j++) wrom[j] = 8'd1;
        feat = '0;
        set_x(0, 16'hFFFF);
        kick();
        wait_done(lat);
        set_exp(16'hFFFF, 16'd2047, 16'd0);
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a]) begin
                n_fail++;
                $display("FAIL floor act%0d: got %h expected %h", a, dout[a], exp_v[a]);
            end
        end
    endtask

    task automatic test_per_neuron_hold();
        int lat;
        fill(8'd0, 8'd0);
        for (int j = 0; j < N; j++) brom[j] = 8'(j - 12);
        kick();
        repeat (599) @(posedge clk);
        #1;
        set_exp(16'hFFFF, 16'd2047, 16'd0);
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a] || busy_v[a] !== 1'b1) begin
                n_fail++;
                $display("FAIL hold act%0d: got %h busy %b, expected %h busy 1", a, dout[a], busy_v[a], exp_v[a]);
            end
        end
        wait_done(lat);
        n_chk++;
        if (lat + 599 != LAT) begin
            n_fail++;
            $display("FAIL neuron_latency: done at %0d, expected %0d", lat + 599, LAT);
        end
        for (int j = 0; j < N; j++) begin
            int v;
            v = 16 * (j - 12);
            exp_v[0][j*OUT_W +: OUT_W] = 16'(v);
            exp_v[1][j*OUT_W +: OUT_W] = 16'(4 * (j - 12) + 2048);
            exp_v[2][j*OUT_W +: OUT_W] = v < 0 ? 16'd0 : 16'(v);
        end
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a]) begin
                n_fail++;
                $display("FAIL per_neuron act%0d: got %h expected %h", a, dout[a], exp_v[a]);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        fill(8'd127, 8'd127);
        feat = {M{16'h7FFF}};
        kick();
        wait_done(lat);
        set_exp(16'd4096, 16'd4096, 16'h7FFF);
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a]) begin
                n_fail++;
                $display("FAIL sat_pos act%0d: got %h expected %h", a, dout[a], exp_v[a]);
            end
        end
        fill(8'h80, 8'd127);
        kick();
        wait_done(lat);
        set_exp(16'hF000, 16'd0, 16'd0);
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a]) begin
                n_fail++;
                $display("FAIL sat_neg act%0d: got %h expected %h", a, dout[a], exp_v[a]);
            end
        end
    endtask

    task automatic test_addr_trace();
        int c;
        fill(8'd127, 8'd127);
        feat = {M{16'h7FFF}};
        kick();
        c = 1;
        while (done_v[0] !== 1'b1 && c < 3000) begin
            if (c == 1) begin
                n_chk++;
                if (waddr !== 10'd0 || baddr !== 5'd0) begin
                    n_fail++;
                    $display("FAIL trace_bias: w_addr %0d b_addr %0d, expected 0 0", waddr, baddr);
                end
            end
            if (c >= 2 && c <= 43) begin
                n_chk++;
                if (waddr !== 10'((c - 2) * N)) begin
                    n_fail++;
                    $display("FAIL trace_n0 cycle %0d: w_addr %0d, expected %0d", c, waddr, (c - 2) * N);
                end
            end
            if (c == 1078) begin
                n_chk++;
                if (waddr !== 10'd1007 || baddr !== 5'd23) begin
                    n_fail++;
                    $display("FAIL trace_n23: w_addr %0d b_addr %0d, expected 1007 23", waddr, baddr);
                end
            end
            if (c == 299) begin
                start = 1;
                feat = '0;
            end
            if (c == 300) begin
                start = 0;
                feat = {M{16'h7FFF}};
            end
            @(posedge clk);
            #1;
            c++;
        end
        n_chk++;
        if (c != LAT) begin
            n_fail++;
            $display("FAIL ignored_start_latency: done at %0d, expected %0d", c, LAT);
        end
        set_exp(16'd4096, 16'd4096, 16'h7FFF);
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a]) begin
                n_fail++;
                $display("FAIL ignored_start act%0d: got %h expected %h", a, dout[a], exp_v[a]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, held_bad;
        fill(8'd0, 8'd1);
        feat = '0;
        kick();
        repeat (499) @(posedge clk);
        #1;
        rst = 1;
        #1;
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (busy_v[a] !== 1'b0 || dout[a] !== '0) begin
                n_fail++;
                $display("FAIL reset_mid act%0d: busy %b out %h, expected 0 and zero", a, busy_v[a], dout[a]);
            end
        end
        @(negedge clk);
        rst = 0;
        kick();
        held_bad = 0;
        lat = 1;
        while (done_v[0] !== 1'b1 && lat < 3000) begin
            if (dout[0] !== '0 || dout[1] !== '0 || dout[2] !== '0) held_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        n_chk++;
        if (held_bad != 0 || lat != LAT) begin
            n_fail++;
            $display("FAIL after_reset: %0d early updates, done at %0d, expected 0 and %0d", held_bad, lat, LAT);
        end
        set_exp(16'd16, 16'd2052, 16'd16);
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a]) begin
                n_fail++;
                $display("FAIL after_reset act%0d: got %h expected %h", a, dout[a], exp_v[a]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        fill(8'd0, 8'd0);
        for (int j = 0; j < N; j++) wrom[j] = 8'd64;
        feat = '0;
        set_x(0, 16'hF000);
        test_weight();
        set_x(0, 16'hF000);
        kick();
        n_chk++;
        if (busy_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy %b, expected 1", busy_v[0]);
        end
        wait_done(lat);
        n_chk++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL b2b_latency: done at %0d, expected %0d", lat, LAT);
        end
        set_exp(16'hFC00, 16'd1792, 16'd0);
        for (int a = 0; a < 3; a++) begin
            n_chk++;
            if (dout[a] !== exp_v[a]) begin
                n_fail++;
                $display("FAIL b2b act%0d: got %h expected %h", a, dout[a], exp_v[a]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bias();
        test_weight();
        test_pairing();
        test_floor();
        test_per_neuron_hold();
        test_saturation();
        test_addr_trace();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
